// File: rtl/dac_transmitter_tc2bo.sv
// DAC transmitter: two's-complement words in, offset-binary LANES-wide groups out,
// with midscale/ramp test patterns and a saturating underflow counter.

module dac_tx_lane_tc2bo (
    input  logic [1:0] sel_i,
    input  logic [7:0] smp_i,
    input  logic [7:0] ramp_i,
    output logic [7:0] out_o
);
    always_comb begin
        case (sel_i)
            2'd0:    out_o = {~smp_i[7], smp_i[6:0]};
            2'd2:    out_o = ramp_i;
            default: out_o = 8'h80;
        endcase
    end
endmodule

module dac_transmitter_tc2bo #(
    parameter int PORTS = 8,
    parameter int LANES = 2
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        ENABLE,
    input  logic [1:0]                  TEST_MODE,
    input  logic                        CNT_CLR,
    input  logic [PORTS-1:0][7:0]       S_DATA,
    input  logic                        S_VALID,
    output logic                        S_READY,
    output logic [LANES-1:0][7:0]       DAC_DATA,
    output logic                        DAC_VALID,
    output logic                        UNDERFLOW,
    output logic [15:0]                 UNDERFLOW_CNT
);
    localparam int R  = PORTS / LANES;
    localparam int PW = (R > 1) ? $clog2(R) : 1;

    localparam logic [1:0] SEL_DATA = 2'd0;
    localparam logic [1:0] SEL_MID  = 2'd1;
    localparam logic [1:0] SEL_RAMP = 2'd2;

    // Words are kept grouped as [group][lane] so the phase indexes a group directly.
    logic [R-1:0][LANES-1:0][7:0] h_q, h_d, sr_q, sr_d, src_w;
    logic                         hf_q, hf_d;
    logic [PW-1:0]                p_q, p_d, p_nxt;
    logic                         primed_q, primed_d;
    logic [7:0]                   ramp_q, ramp_d;
    logic [LANES-1:0][7:0]        dac_q, dac_d, grp;
    logic                         dval_q;
    logic                         uf_q, uf_d;
    logic [15:0]                  cnt_q, cnt_d;

    logic data_mode, ramp_mode, load, starve, accept;
    logic [1:0] sel;

    assign data_mode = (TEST_MODE == 2'b00);
    assign ramp_mode = (TEST_MODE == 2'b10);
    assign load      = (p_q == '0) && hf_q;
    assign starve    = (p_q == '0) && !hf_q;
    assign S_READY   = RST_N && ENABLE && data_mode && (!hf_q || (p_q == '0));
    assign accept    = S_VALID && S_READY;
    assign p_nxt     = (p_q == PW'(R - 1)) ? '0 : p_q + 1'b1;

    assign src_w = load ? h_q : sr_q;
    assign grp   = src_w[p_q];

    always_comb begin
        sel = SEL_MID;
        if (ENABLE) begin
            if (data_mode)      sel = starve ? SEL_MID : SEL_DATA;
            else if (ramp_mode) sel = SEL_RAMP;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        dac_tx_lane_tc2bo u_lane (
            .sel_i  (sel),
            .smp_i  (grp[l]),
            .ramp_i (ramp_q + 8'(l)),
            .out_o  (dac_d[l])
        );
    end

    always_comb begin
        h_d      = h_q;
        hf_d     = hf_q;
        sr_d     = sr_q;
        p_d      = p_q;
        primed_d = primed_q;
        ramp_d   = 8'h00;
        uf_d     = 1'b0;
        cnt_d    = cnt_q;
        if (!ENABLE) begin
            hf_d     = 1'b0;
            p_d      = '0;
            primed_d = 1'b0;
        end else if (!data_mode) begin
            // Test patterns abandon any partial word but keep the held one.
            p_d = '0;
            if (ramp_mode) ramp_d = ramp_q + 8'(LANES);
        end else begin
            if (load) begin
                sr_d     = h_q;
                hf_d     = 1'b0;
                primed_d = 1'b1;
                p_d      = p_nxt;
            end else if (p_q != '0) begin
                p_d = p_nxt;
            end else if (primed_q) begin
                uf_d = 1'b1;
                if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end
            if (accept) begin
                h_d  = S_DATA;
                hf_d = 1'b1;
            end
        end
        if (CNT_CLR) cnt_d = 16'h0000;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_q      <= '0;
            hf_q     <= 1'b0;
            sr_q     <= '0;
            p_q      <= '0;
            primed_q <= 1'b0;
            ramp_q   <= 8'h00;
            dac_q    <= {LANES{8'h80}};
            dval_q   <= 1'b0;
            uf_q     <= 1'b0;
            cnt_q    <= 16'h0000;
        end else begin
            h_q      <= h_d;
            hf_q     <= hf_d;
            sr_q     <= sr_d;
            p_q      <= p_d;
            primed_q <= primed_d;
            ramp_q   <= ramp_d;
            dac_q    <= dac_d;
            dval_q   <= ENABLE;
            uf_q     <= uf_d;
            cnt_q    <= cnt_d;
        end
    end

    assign DAC_DATA      = dac_q;
    assign DAC_VALID     = dval_q;
    assign UNDERFLOW     = uf_q;
    assign UNDERFLOW_CNT = cnt_q;
endmodule

// File: tb/tb_dac_transmitter_tc2bo.sv
// Directed bench for dac_transmitter_tc2bo: an R=4 instance and an R=1 instance.

module tb_dac_transmitter_tc2bo;
    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RST_N, ENABLE, CNT_CLR, S_VALID, S_READY, DAC_VALID, UNDERFLOW;
    logic [1:0] TEST_MODE;
    logic [7:0][7:0] S_DATA;
    logic [1:0][7:0] DAC_DATA;
    logic [15:0] UNDERFLOW_CNT;

    logic en1, clr1, sv1, sr1, dv1, uf1;
    logic [1:0] tm1;
    logic [1:0][7:0] sd1, dd1;
    logic [15:0] cnt1;

    dac_transmitter_tc2bo #(.PORTS(8), .LANES(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(ENABLE), .TEST_MODE(TEST_MODE),
        .CNT_CLR(CNT_CLR), .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
        .DAC_DATA(DAC_DATA), .DAC_VALID(DAC_VALID), .UNDERFLOW(UNDERFLOW),
        .UNDERFLOW_CNT(UNDERFLOW_CNT)
    );

    dac_transmitter_tc2bo #(.PORTS(2), .LANES(2)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .ENABLE(en1), .TEST_MODE(tm1),
        .CNT_CLR(clr1), .S_DATA(sd1), .S_VALID(sv1), .S_READY(sr1),
        .DAC_DATA(dd1), .DAC_VALID(dv1), .UNDERFLOW(uf1),
        .UNDERFLOW_CNT(cnt1)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [7:0] cv(input logic [7:0] x);
        return {~x[7], x[6:0]};
    endfunction

    logic [63:0] words [8];
    logic [63:0] w;
    logic [15:0] exp16;
    int wi, hs;
    logic rdy;

    initial begin
        RST_N = 1'b0; ENABLE = 1'b1; TEST_MODE = 2'b00; CNT_CLR = 1'b0;
        S_VALID = 1'b0; S_DATA = '0;
        en1 = 1'b0; tm1 = 2'b00; clr1 = 1'b0; sv1 = 1'b0; sd1 = '0;
        #12;
        chk("rst_dac", DAC_DATA, 16'h8080);
        chk("rst_valid", DAC_VALID, 1'b0);
        chk("rst_uf", UNDERFLOW, 1'b0);
        chk("rst_cnt", UNDERFLOW_CNT, 16'h0);
        chk("rst_ready", S_READY, 1'b0);
        RST_N = 1'b1;

        // Directed word; first group one edge after the handshake.
        S_DATA = 64'h40F0107F0100FF80; S_VALID = 1'b1;
        #1 chk("idle_ready", S_READY, 1'b1);
        tick();
        chk("hs_dac", DAC_DATA, 16'h8080);
        chk("hs_valid", DAC_VALID, 1'b1);
        chk("startup_cnt", UNDERFLOW_CNT, 16'h0);
        S_VALID = 1'b0;
        tick(); chk("vec_g0", DAC_DATA, 16'h7F00);
        tick(); chk("vec_g1", DAC_DATA, 16'h8180);
        tick(); chk("vec_g2", DAC_DATA, 16'h90FF);
        tick(); chk("vec_g3", DAC_DATA, 16'hC070);
        tick();
        chk("starve_dac", DAC_DATA, 16'h8080);
        chk("starve_uf", UNDERFLOW, 1'b1);
        chk("starve_cnt1", UNDERFLOW_CNT, 16'd1);
        tick(); chk("starve_cnt2", UNDERFLOW_CNT, 16'd2);
        CNT_CLR = 1'b1;
        tick();
        chk("clr_cnt", UNDERFLOW_CNT, 16'd0);
        chk("clr_uf", UNDERFLOW, 1'b1);

        // Back-to-back stream of random words.
        for (int i = 0; i < 8; i++) words[i] = {$urandom, $urandom};
        S_DATA = words[0]; S_VALID = 1'b1;
        tick();
        CNT_CLR = 1'b0;
        wi = 1; hs = 0;
        S_DATA = words[1];
        for (int c = 0; c < 32; c++) begin
            rdy = S_READY && S_VALID;
            tick();
            if (rdy) begin wi++; hs++; end
            if (wi < 8) S_DATA = words[wi];
            else S_VALID = 1'b0;
            w = words[c / 4];
            exp16 = {cv(w[(c % 4) * 16 + 8 +: 8]), cv(w[(c % 4) * 16 +: 8])};
            chk("stream", DAC_DATA, exp16);
        end
        chk("stream_hs", hs, 7);
        chk("stream_cnt", UNDERFLOW_CNT, 16'd0);

        // Test mode mid-word drops the remainder; held word follows.
        S_DATA = 64'h40F0107F0100FF80; S_VALID = 1'b1;
        tick();
        S_DATA = 64'h0706050403020100;
        tick(); chk("mw_a0", DAC_DATA, 16'h7F00);
        S_VALID = 1'b0;
        tick(); chk("mw_a1", DAC_DATA, 16'h8180);
        TEST_MODE = 2'b01;
        tick();
        chk("mw_mid", DAC_DATA, 16'h8080);
        chk("mw_ready", S_READY, 1'b0);
        TEST_MODE = 2'b00;
        #1 chk("mw_resume_ready", S_READY, 1'b1);
        tick(); chk("mw_b0", DAC_DATA, 16'h8180);
        tick(); chk("mw_b1", DAC_DATA, 16'h8382);
        tick(); tick();

        // Ramp pattern with wrap, then midscale.
        TEST_MODE = 2'b10;
        tick();
        chk("ramp0", DAC_DATA, 16'h0100);
        chk("ramp_ready", S_READY, 1'b0);
        for (int k = 1; k < 128; k++) begin
            tick();
            chk("ramp", DAC_DATA, {8'(2 * k + 1), 8'(2 * k)});
        end
        tick();
        chk("ramp_wrap", DAC_DATA, 16'h0100);
        chk("ramp_uf", UNDERFLOW, 1'b0);
        TEST_MODE = 2'b01;
        tick();
        chk("mid_dac", DAC_DATA, 16'h8080);
        chk("mid_valid", DAC_VALID, 1'b1);

        // Disable keeps the count.
        TEST_MODE = 2'b00; CNT_CLR = 1'b1;
        tick(); chk("clr2_cnt", UNDERFLOW_CNT, 16'd0);
        CNT_CLR = 1'b0;
        tick(); chk("uf_cnt1", UNDERFLOW_CNT, 16'd1);
        ENABLE = 1'b0;
        tick();
        chk("dis_valid", DAC_VALID, 1'b0);
        chk("dis_dac", DAC_DATA, 16'h8080);
        chk("dis_cnt", UNDERFLOW_CNT, 16'd1);
        chk("dis_uf", UNDERFLOW, 1'b0);
        ENABLE = 1'b1;

        // Restart is unprimed; then reset mid-word.
        S_DATA = 64'h40F0107F0100FF80; S_VALID = 1'b1;
        tick();
        chk("reprime_cnt", UNDERFLOW_CNT, 16'd1);
        S_VALID = 1'b0;
        tick(); chk("rw_g0", DAC_DATA, 16'h7F00);
        #3 RST_N = 1'b0;
        #1;
        chk("arst_dac", DAC_DATA, 16'h8080);
        chk("arst_valid", DAC_VALID, 1'b0);
        chk("arst_ready", S_READY, 1'b0);
        chk("arst_cnt", UNDERFLOW_CNT, 16'd0);
        ENABLE = 1'b0;
        RST_N = 1'b1;
        #1 chk("post_rst_ready_dis", S_READY, 1'b0);
        ENABLE = 1'b1;
        #1 chk("post_rst_ready_en", S_READY, 1'b1);

        // R = 1 at full rate.
        en1 = 1'b1; sv1 = 1'b1; sd1 = 16'h7F80;
        #1 chk("r1_ready0", sr1, 1'b1);
        tick(); chk("r1_first", dd1, 16'h8080);
        sd1 = 16'h0100;
        #1 chk("r1_ready1", sr1, 1'b1);
        tick(); chk("r1_w0", dd1, 16'hFF00);
        sd1 = 16'hFF10;
        #1 chk("r1_ready2", sr1, 1'b1);
        tick(); chk("r1_w1", dd1, 16'h8180);
        sv1 = 1'b0;
        tick();
        chk("r1_w2", dd1, 16'h7F90);
        chk("r1_cnt0", cnt1, 16'd0);
        tick();
        chk("r1_uf", uf1, 1'b1);
        chk("r1_cnt1", cnt1, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dac_transmitter_tc2bo.md
Name: dac_transmitter_tc2bo

Overview:
- DAC-side counterpart of the ADC receiver path.
- Accepts words of PORTS two's-complement 8-bit samples over a valid/ready handshake and converts each sample to offset binary (invert MSB).
- Serialises each word onto a narrower LANES-wide DAC bus, R = PORTS/LANES cycles per word, lowest-index samples first.
- Provides midscale and ramp test patterns, and counts underflow when the source starves the DAC.

Parameters:
- PORTS, 8, samples per input word.
- LANES, 2, samples per DAC cycle. PORTS must be divisible by LANES; R = PORTS/LANES, R >= 1.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ENABLE  input  1  run enable.
- TEST_MODE  input  2  00 = data, 01 = midscale, 10 = ramp, 11 = midscale.
- CNT_CLR  input  1  synchronous clear of UNDERFLOW_CNT.
- S_DATA  input  [PORTS-1:0][7:0]  two's-complement samples; index 0 is sent first.
- S_VALID  input  1  S_DATA valid.
- S_READY  output  1  block can accept a word.
- DAC_DATA  output  [LANES-1:0][7:0]  offset-binary samples, registered.
- DAC_VALID  output  1  DAC_DATA valid, registered.
- UNDERFLOW  output  1  one-cycle pulse on each starved slot.
- UNDERFLOW_CNT  output  16  saturating underflow count.

Behaviour:
- Reset (RST_N = 0, asynchronous):
  - DAC_DATA = 0x80 on every lane; DAC_VALID = 0; UNDERFLOW = 0; UNDERFLOW_CNT = 0.
  - Internal: hold-full flag hf = 0, phase p = 0, primed = 0, ramp = 0.
  - S_READY = 0 while in reset.
- Internal state:
  - Hold register H (one word) with flag hf.
  - Shift register SR (one word).
  - Phase p in 0..R-1, meaning the next lane group to emit; p == 0 marks a word boundary.
- S_READY = ENABLE && TEST_MODE == 00 && (!hf || p == 0). It is derived from registers and inputs only; there is no path from S_VALID.
- Handshake: on S_VALID && S_READY at an edge, H <= S_DATA and hf <= 1.
  - If the same edge also loads SR from H, the new word replaces H and hf stays 1.
- Conversion, per sample: out = {~x[7], x[6:0]}. Examples: 0x80 -> 0x00, 0x00 -> 0x80, 0x7F -> 0xFF, 0xFF -> 0x7F.
- Data mode, each edge with ENABLE = 1 and TEST_MODE = 00:
  - p == 0 and hf = 1: SR <= H; DAC_DATA <= conv(H[LANES-1:0]); hf <= 0 unless refilled on this edge; primed <= 1; p <= 1 mod R.
  - p != 0: DAC_DATA <= conv(SR group p), i.e. samples p*LANES to p*LANES+LANES-1; p <= (p+1) mod R.
  - p == 0 and hf = 0: DAC_DATA <= 0x80 on all lanes; p stays 0.
    - If primed = 1: UNDERFLOW <= 1 and UNDERFLOW_CNT increments, saturating at 0xFFFF.
    - Start-up starvation (primed = 0) is not counted.
- Latency: a word handshaken at edge k with the block idle at boundary has lanes 0..LANES-1 on DAC_DATA after edge k+1.
- Throughput: one word per R cycles, with no bubbles while the source keeps S_VALID high. This includes R = 1.
- Test modes (TEST_MODE != 00, ENABLE = 1):
  - S_READY = 0; H and hf are preserved; p is forced to 0, so a partially sent word is abandoned.
  - No underflow is counted.
  - Midscale: DAC_DATA = 0x80 on all lanes.
  - Ramp: lane i = ramp + i (mod 256); ramp <= ramp + LANES each cycle. Ramp resets to 0 on entry to ramp mode.
  - Values are already offset binary, so no conversion is applied.
  - On return to 00, the block resumes at a boundary; a held word is sent first.
- ENABLE = 0, next edge:
  - DAC_VALID <= 0; DAC_DATA <= 0x80.
  - hf, p, primed and ramp are cleared.
  - UNDERFLOW_CNT is retained.
- DAC_VALID <= ENABLE, registered; it is high whenever the block is running, including underflow and test modes.
- CNT_CLR clears UNDERFLOW_CNT on the next edge and has priority over an increment in the same cycle. The UNDERFLOW pulse is unaffected.
- TEST_MODE changes mid-word take effect on the next edge. Reset mid-word returns the block to its reset state immediately.

Test Plan:
- PORTS = 8, LANES = 2, ENABLE = 1, one word S_DATA[0..7] = 0x80, 0xFF, 0x00, 0x01, 0x7F, 0x10, 0xF0, 0x40 -> DAC_DATA over 4 consecutive cycles:
  - (0x00, 0x7F)
  - (0x80, 0x81)
  - (0xFF, 0x90)
  - (0x70, 0xC0)
  - First group appears 1 edge after the handshake.
- Continuous S_VALID with 64 random words -> no gaps, S_READY duty 1/4, UNDERFLOW_CNT = 0, output stream equals the converted input in order.
- Starvation: send 1 word, then S_VALID = 0 for 6 cycles -> 4 data cycles, then 0x80 on all lanes with UNDERFLOW pulsing every cycle; count = 6 minus the initial boundary offset. Before the first word, the count stays 0.
- TEST_MODE = 10 with LANES = 2 -> DAC_DATA (0,1), (2,3), …, wrapping (254,255) -> (0,1); S_READY = 0 throughout. Switching to 01 gives constant 0x80.
- Switch TEST_MODE 00 -> 01 at p = 2 mid-word, then back -> remainder of that word is dropped; the held next word is emitted starting from lanes 0/1.
- RST_N asserted mid-word -> outputs are immediately 0x80 and DAC_VALID = 0; after release, S_READY goes high only once ENABLE = 1. Separately, CNT_CLR together with an underflow -> count = 0. Also run the R = 1 configuration (PORTS = LANES = 2) at full rate.
